// File: rtl/cms_trace_packetizer_pkg.sv
// Shared constants for the trace packetizer: opcodes, control map, filter bits, trigger states.
package cms_trace_packetizer_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] INSTR_WFI = 32'h10500073;

  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_MASK       = 1;
  localparam int unsigned CTRL_TRIG_START = 2;
  localparam int unsigned CTRL_TRIG_STOP  = 3;
  localparam int unsigned CTRL_TRIG_MODE  = 4;
  localparam int unsigned CTRL_INTERVAL   = 5;
  localparam int unsigned CTRL_DROP_CLR   = 6;
  localparam int unsigned CTRL_FLUSH      = 7;

  localparam int unsigned FLT_ANY    = 0;
  localparam int unsigned FLT_BRANCH = 1;
  localparam int unsigned FLT_JAL    = 2;
  localparam int unsigned FLT_JALR   = 3;

  typedef enum logic [1:0] {
    TRIG_IDLE,
    TRIG_ARMED,
    TRIG_CAPTURE
  } trig_state_e;

  // WFI is excluded regardless of the mask.
  function automatic logic instr_match(input logic [3:0] mask, input logic [31:0] ins);
    logic hit;
    hit = mask[FLT_ANY]
        | (mask[FLT_BRANCH] & (ins[6:0] == OP_BRANCH))
        | (mask[FLT_JAL]    & (ins[6:0] == OP_JAL))
        | (mask[FLT_JALR]   & (ins[6:0] == OP_JALR));
    return hit & (ins != INSTR_WFI);
  endfunction

endpackage

// File: rtl/cms_trace_packetizer_if.sv
// AXI-Stream style handshake bundle carrying the {pc, instr} trace beats.
interface cms_trace_packetizer_if #(
  parameter int unsigned DATA_W = 96
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_trace_packetizer_sync_fifo.sv
// Synchronous FIFO with occupancy count; a pop in the same cycle lets a push into a full FIFO.
module cms_trace_packetizer_sync_fifo #(
  parameter int unsigned WIDTH = 97,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cms_trace_packetizer.sv
// Retired-instruction trace capture: class filter, pc trigger window, FIFO buffering and
// AXI-Stream drain with interval/flush tlast framing.
module cms_trace_packetizer
  import cms_trace_packetizer_pkg::*;
#(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned AXI_DATA_WIDTH  = XLEN + 32,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WE_POSEDGE = 1,
  parameter int unsigned TLAST_DEFAULT   = 100,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          pc,
  input  logic [31:0]              instr,
  input  logic                     pc_valid,
  input  logic [ADDR_WIDTH-1:0]    ctrl_addr,
  input  logic [DATA_WIDTH-1:0]    ctrl_wdata,
  input  logic                     ctrl_write_enable,
  cms_trace_packetizer_if.master   M_AXIS,
  output logic                     capturing,
  output logic [LW-1:0]            fifo_level,
  output logic [31:0]              drop_count
);

  logic            enable_q, enable_d;
  logic [3:0]      mask_q, mask_d;
  logic [XLEN-1:0] trig_start_q, trig_start_d;
  logic [XLEN-1:0] trig_stop_q, trig_stop_d;
  logic [1:0]      trig_mode_q, trig_mode_d;
  logic [31:0]     interval_q, interval_d;
  logic            flush_pend_q, flush_pend_d;
  logic [31:0]     drop_q, drop_d;
  logic [31:0]     beat_cnt_q, beat_cnt_d;
  logic            we_prev_q;
  trig_state_e     state_q, state_d;

  logic                      ctrl_wr;
  logic                      hit_start, hit_stop;
  logic                      enq, pop, push_ok, drop_evt, tlast;
  logic                      fifo_full, fifo_empty;
  logic [AXI_DATA_WIDTH:0]   fifo_dout;

  assign ctrl_wr   = ctrl_write_enable & ((CTRL_WE_POSEDGE == 0) | ~we_prev_q);
  assign hit_start = pc_valid & (pc == trig_start_q);
  assign hit_stop  = pc_valid & trig_mode_q[1] & (pc == trig_stop_q);

  // Trigger FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= TRIG_IDLE;
    else     state_q <= state_d;
  end

  // Trigger FSM: next state. IDLE behaves like ARMED once enabled so a start hit is never missed.
  always_comb begin
    state_d = state_q;
    if (!enable_q || !trig_mode_q[0]) begin
      state_d = TRIG_IDLE;
    end else begin
      unique case (state_q)
        TRIG_IDLE, TRIG_ARMED: state_d = (hit_start && !hit_stop) ? TRIG_CAPTURE : TRIG_ARMED;
        TRIG_CAPTURE:          state_d = hit_stop ? TRIG_ARMED : TRIG_CAPTURE;
        default:               state_d = TRIG_IDLE;
      endcase
    end
  end

  // Trigger FSM: outputs
  always_comb begin
    capturing = 1'b0;
    if (enable_q) begin
      if (!trig_mode_q[0]) capturing = 1'b1;
      else                 capturing = (state_q == TRIG_CAPTURE) | hit_start;
    end
  end

  assign enq      = pc_valid & capturing & instr_match(mask_q, instr);
  assign pop      = ~fifo_empty & M_AXIS.tready;
  assign push_ok  = enq & (~fifo_full | pop);
  assign drop_evt = enq & fifo_full & ~pop;
  assign tlast    = ~fifo_empty & (fifo_dout[AXI_DATA_WIDTH]
                                   | (interval_q <= 32'd1)
                                   | (beat_cnt_q >= interval_q - 32'd1));

  always_comb begin
    enable_d     = enable_q;
    mask_d       = mask_q;
    trig_start_d = trig_start_q;
    trig_stop_d  = trig_stop_q;
    trig_mode_d  = trig_mode_q;
    interval_d   = interval_q;
    flush_pend_d = flush_pend_q;
    drop_d       = drop_q;
    beat_cnt_d   = beat_cnt_q;

    if (push_ok) flush_pend_d = 1'b0;
    if (drop_evt && drop_q != '1) drop_d = drop_q + 32'd1;
    if (pop) beat_cnt_d = tlast ? '0 : beat_cnt_q + 32'd1;

    // A control write lands after the datapath updates so clear/flush take precedence.
    if (ctrl_wr) begin
      case (ctrl_addr)
        ADDR_WIDTH'(CTRL_ENABLE):     enable_d     = ctrl_wdata[0];
        ADDR_WIDTH'(CTRL_MASK):       mask_d       = ctrl_wdata[3:0];
        ADDR_WIDTH'(CTRL_TRIG_START): trig_start_d = XLEN'(ctrl_wdata);
        ADDR_WIDTH'(CTRL_TRIG_STOP):  trig_stop_d  = XLEN'(ctrl_wdata);
        ADDR_WIDTH'(CTRL_TRIG_MODE):  trig_mode_d  = ctrl_wdata[1:0];
        ADDR_WIDTH'(CTRL_INTERVAL):   interval_d   = ctrl_wdata[31:0];
        ADDR_WIDTH'(CTRL_DROP_CLR):   drop_d       = '0;
        ADDR_WIDTH'(CTRL_FLUSH):      flush_pend_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q     <= 1'b0;
      mask_q       <= 4'b0001;
      trig_start_q <= '0;
      trig_stop_q  <= '0;
      trig_mode_q  <= '0;
      interval_q   <= 32'(TLAST_DEFAULT);
      flush_pend_q <= 1'b0;
      drop_q       <= '0;
      beat_cnt_q   <= '0;
      we_prev_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      mask_q       <= mask_d;
      trig_start_q <= trig_start_d;
      trig_stop_q  <= trig_stop_d;
      trig_mode_q  <= trig_mode_d;
      interval_q   <= interval_d;
      flush_pend_q <= flush_pend_d;
      drop_q       <= drop_d;
      beat_cnt_q   <= beat_cnt_d;
      we_prev_q    <= ctrl_write_enable;
    end
  end

  cms_trace_packetizer_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   ({flush_pend_q, pc, instr}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign M_AXIS.tvalid = ~fifo_empty;
  assign M_AXIS.tdata  = fifo_empty ? '0 : fifo_dout[AXI_DATA_WIDTH-1:0];
  assign M_AXIS.tlast  = tlast;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_cms_trace_packetizer.sv
// Bench for cms_trace_packetizer: directed scenarios plus random traffic against a queue model.
module tb_cms_trace_packetizer;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        pc_valid;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_we;
  logic        capturing;
  logic [4:0]  fifo_level;
  logic [31:0] drop_count;

  cms_trace_packetizer_if #(.DATA_W(96)) axis ();

  always #5 clk = ~clk;

  cms_trace_packetizer #(
    .XLEN            (64),
    .AXI_DATA_WIDTH  (96),
    .FIFO_DEPTH      (DEPTH),
    .ADDR_WIDTH      (8),
    .DATA_WIDTH      (64),
    .CTRL_WE_POSEDGE (1),
    .TLAST_DEFAULT   (100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc                (pc),
    .instr             (instr),
    .pc_valid          (pc_valid),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_we),
    .M_AXIS            (axis),
    .capturing         (capturing),
    .fifo_level        (fifo_level),
    .drop_count        (drop_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned beats;
  logic [63:0] tl_mask;

  // Reference model state
  logic [96:0] m_q[$];
  logic        m_enable, m_flush, m_inside, m_we_prev;
  logic [3:0]  m_mask;
  logic [1:0]  m_mode;
  logic [63:0] m_start, m_stop;
  logic [31:0] m_interval, m_cnt, m_drop;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_enable = 0; m_mask = 4'b0001; m_start = '0; m_stop = '0; m_mode = '0;
    m_interval = 100; m_cnt = 0; m_drop = 0; m_flush = 0; m_inside = 0; m_we_prev = 0;
  endtask

  function automatic bit m_match(input logic [3:0] m, input logic [31:0] ins);
    if (ins == 32'h10500073) return 1'b0;
    return m[0] || (m[1] && ins[6:0] == 7'h63) || (m[2] && ins[6:0] == 7'h6f)
                || (m[3] && ins[6:0] == 7'h67);
  endfunction

  function automatic bit m_open();
    return m_enable && (!m_mode[0] || m_inside || (pc_valid && pc == m_start));
  endfunction

  // Inputs are set at the negedge; check outputs, advance the model, move to next negedge.
  task automatic tick();
    logic        t_last, pop, enq, full_pre, wr;
    logic [96:0] head;
    #1;
    t_last = 1'b0;
    chk("tvalid", axis.tvalid, m_q.size() != 0);
    chk("level", fifo_level, m_q.size());
    chk("drops", drop_count, m_drop);
    chk("capturing", capturing, m_open());
    if (m_q.size() != 0) begin
      head   = m_q[0];
      t_last = head[96] || m_interval <= 1 || m_cnt >= m_interval - 1;
      chk("tdata", axis.tdata, head[95:0]);
      chk("tlast", axis.tlast, t_last);
    end
    if (axis.tvalid === 1'b1 && axis.tready) begin
      beats++;
      if (axis.tlast === 1'b1 && beats < 64) tl_mask[beats] = 1'b1;
    end
    if (rst) begin
      m_reset();
    end else begin
      full_pre = (m_q.size() == DEPTH);
      pop      = axis.tready && m_q.size() != 0;
      enq      = pc_valid && m_open() && m_match(m_mask, instr);
      if (pop) begin
        m_cnt = t_last ? 0 : m_cnt + 1;
        void'(m_q.pop_front());
      end
      if (enq) begin
        if (!full_pre || pop) begin
          m_q.push_back({m_flush, pc, instr});
          m_flush = 0;
        end else if (m_drop != 32'hffff_ffff) m_drop++;
      end
      if (!m_enable || !m_mode[0]) m_inside = 0;
      else m_inside = (m_inside || (pc_valid && pc == m_start))
                      && !(pc_valid && m_mode[1] && pc == m_stop);
      wr = ctrl_we && !m_we_prev;
      m_we_prev = ctrl_we;
      if (wr) begin
        case (ctrl_addr)
          8'd0: m_enable   = ctrl_wdata[0];
          8'd1: m_mask     = ctrl_wdata[3:0];
          8'd2: m_start    = ctrl_wdata;
          8'd3: m_stop     = ctrl_wdata;
          8'd4: m_mode     = ctrl_wdata[1:0];
          8'd5: m_interval = ctrl_wdata[31:0];
          8'd6: m_drop     = 0;
          8'd7: m_flush    = 1;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [63:0] d);
    pc_valid = 0; ctrl_addr = a; ctrl_wdata = d; ctrl_we = 1;
    tick();
    ctrl_we = 0;
    tick();
  endtask

  task automatic send(input logic [63:0] p, input logic [31:0] ins);
    pc = p; instr = ins; pc_valid = 1;
    tick();
    pc_valid = 0;
  endtask

  logic [31:0] itab [6];

  initial begin
    itab[0] = 32'h00000013; itab[1] = 32'h0000006f; itab[2] = 32'h00004063;
    itab[3] = 32'h00008067; itab[4] = 32'h10500073; itab[5] = 32'h00000033;
    rst = 1; pc = '0; instr = '0; pc_valid = 0; ctrl_addr = '0; ctrl_wdata = '0; ctrl_we = 0;
    axis.tready = 0; beats = 0; tl_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
    rst = 0;
    #1;
    chk("reset_tvalid", axis.tvalid, 1'b0);
    chk("reset_tdata", axis.tdata, 96'h0);
    chk("reset_level", fifo_level, 5'd0);
    chk("reset_capturing", capturing, 1'b0);

    // Interval framing with every class accepted
    axis.tready = 1;
    wr_reg(8'd5, 64'd4);
    wr_reg(8'd1, 64'h1);
    wr_reg(8'd0, 64'h1);
    beats = 0; tl_mask = '0;
    for (int i = 0; i < 10; i++) send(64'h1000 + 64'(4 * i), 32'h00000013);
    repeat (4) tick();
    chk("t1_beats", beats, 10);
    chk("t1_tlast_pos", tl_mask, 64'h110);

    // Class filter: jal + branch only, WFI never
    wr_reg(8'd1, 64'h6);
    beats = 0;
    for (int i = 0; i < 5; i++) send(64'h2000 + 64'(4 * i), itab[i]);
    repeat (4) tick();
    chk("t2_beats", beats, 2);

    // Trigger window 0x20..0x30
    wr_reg(8'd1, 64'h1);
    wr_reg(8'd2, 64'h20);
    wr_reg(8'd3, 64'h30);
    wr_reg(8'd4, 64'h3);
    beats = 0;
    for (int p = 'h10; p <= 'h40; p += 4) send(64'(p), 32'h00000013);
    repeat (4) tick();
    chk("t3_beats", beats, 5);

    // Overflow with the sink stalled
    wr_reg(8'd4, 64'h0);
    axis.tready = 0;
    for (int i = 0; i < 20; i++) send(64'h3000 + 64'(4 * i), 32'h00000013);
    tick();
    chk("t4_level", fifo_level, 5'd16);
    chk("t4_drops", drop_count, 32'd4);
    wr_reg(8'd6, 64'h0);
    chk("t4_drop_clear", drop_count, 32'd0);
    axis.tready = 1;
    repeat (20) tick();

    // Held strobe only acts on its rising edge
    pc_valid = 0; ctrl_addr = 8'd5; ctrl_wdata = 64'd3; ctrl_we = 1;
    tick();
    ctrl_wdata = 64'd7;
    tick();
    ctrl_we = 0;
    tick();

    // Toggling ready, flush-tagged entries
    wr_reg(8'd7, 64'h0);
    for (int i = 0; i < 40; i++) begin
      axis.tready = (i % 2) != 0;
      pc = 64'h4000 + 64'(4 * i); instr = itab[$urandom_range(0, 5)];
      pc_valid = ($urandom % 2) != 0;
      tick();
    end
    pc_valid = 0; axis.tready = 1;
    repeat (20) tick();

    // Random traffic with random control writes
    wr_reg(8'd1, 64'hf);
    for (int i = 0; i < 800; i++) begin
      axis.tready = $urandom_range(0, 3) != 0;
      pc_valid    = ($urandom % 2) != 0;
      pc          = 64'({$urandom_range(0, 15), 2'b00});
      instr       = itab[$urandom_range(0, 5)];
      ctrl_we     = ($urandom % 8) == 0;
      ctrl_addr   = 8'($urandom_range(0, 9));
      case (ctrl_addr)
        8'd0:       ctrl_wdata = 64'(($urandom % 4) != 0);
        8'd2, 8'd3: ctrl_wdata = 64'({$urandom_range(0, 15), 2'b00});
        8'd5:       ctrl_wdata = 64'($urandom_range(0, 6));
        default:    ctrl_wdata = {$urandom, $urandom};
      endcase
      tick();
    end
    ctrl_we = 0; pc_valid = 0; axis.tready = 1;
    repeat (20) tick();

    // Reset with entries queued
    wr_reg(8'd0, 64'h1);
    wr_reg(8'd1, 64'h1);
    wr_reg(8'd4, 64'h0);
    axis.tready = 0;
    for (int i = 0; i < 5; i++) send(64'h5000 + 64'(4 * i), 32'h00000013);
    chk("t6_level_pre", fifo_level, 5'd5);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_tvalid", axis.tvalid, 1'b0);
    chk("t6_level", fifo_level, 5'd0);
    chk("t6_capturing", capturing, 1'b0);
    chk("t6_drops", drop_count, 32'd0);
    axis.tready = 1;
    wr_reg(8'd0, 64'h1);
    send(64'h6000, 32'h0000006f);
    send(64'h6004, 32'h00000013);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
